// File: rtl/dram_wait.sv
// dram_wait: word-organised data memory with programmable access latency,
// byte-lane writes, misalignment detection and a one-cycle Ready pulse.
// Memory contents read as zero after reset via a per-word valid bitmap, so
// the storage array itself needs no reset.
module dram_wait #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                MemoryEnable,
    input  logic                ReadNotWrite,
    input  logic [DATA_W/8-1:0] ByteEn,
    input  logic [ADDR_W-1:0]   DRAMadd,
    input  logic [DATA_W-1:0]   DRAMin,
    output logic [DATA_W-1:0]   DRAMout,
    output logic                Ready,
    output logic                Misaligned
);

    localparam int LANES = DATA_W / 8;
    localparam int OFF   = $clog2(LANES);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [3:0] LAT = 4'(LATENCY);

    logic [1:0]            state_reg;
    logic [3:0]            cnt_reg;
    logic                  misaligned_reg;
    logic [DEPTH-1:0]      valid_reg;
    logic [DATA_W-1:0]     mem [DEPTH];

    logic                  accept;
    logic                  do_access;
    logic [ADDR_W-1:0]     acc_addr;
    logic                  acc_rnw;
    logic [LANES-1:0]      acc_be;
    logic [DATA_W-1:0]     acc_data;
    logic [DEPTH_LOG2-1:0] idx;
    logic                  mis;
    logic                  wr_en;
    logic [LANES-1:0]      lane_we;
    logic [DATA_W-1:0]     wr_word;

    assign accept = MemoryEnable && (state_reg == IDLE || state_reg == RESP);

    // With zero latency the access happens on the accept edge itself, so the
    // live inputs feed the memory; otherwise the captured request does.
    generate
        if (LATENCY == 0) begin : g_direct
            assign acc_addr  = DRAMadd;
            assign acc_rnw   = ReadNotWrite;
            assign acc_be    = ByteEn;
            assign acc_data  = DRAMin;
            assign do_access = accept;
        end else begin : g_capture
            logic [ADDR_W-1:0] addr_reg;
            logic              rnw_reg;
            logic [LANES-1:0]  be_reg;
            logic [DATA_W-1:0] data_reg;

            // Capture the request at the accept edge; inputs are free afterwards.
            always_ff @(posedge Clk or posedge Rst) begin
                if (Rst) begin
                    addr_reg <= '0;
                    rnw_reg  <= 1'b0;
                    be_reg   <= '0;
                    data_reg <= '0;
                end else if (accept) begin
                    addr_reg <= DRAMadd;
                    rnw_reg  <= ReadNotWrite;
                    be_reg   <= ByteEn;
                    data_reg <= DRAMin;
                end
            end

            assign acc_addr  = addr_reg;
            assign acc_rnw   = rnw_reg;
            assign acc_be    = be_reg;
            assign acc_data  = data_reg;
            assign do_access = (state_reg == BUSY) && (cnt_reg == 4'd1);
        end
    endgenerate

    assign idx = acc_addr[OFF+DEPTH_LOG2-1:OFF];

    generate
        if (OFF == 0) begin : g_no_align
            assign mis = 1'b0;
        end else begin : g_align
            assign mis = |acc_addr[OFF-1:0];
        end
        if (ADDR_W > OFF + DEPTH_LOG2) begin : g_alias
            // High address bits alias and are deliberately ignored.
            logic unused_high_bits;
            assign unused_high_bits = ^acc_addr[ADDR_W-1:OFF+DEPTH_LOG2];
        end
    endgenerate

    // A word never written since reset is treated as zero: the first write
    // to it stores zeros in all disabled lanes instead of merging.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_we[gi]          = acc_be[gi] | ~valid_reg[idx];
            assign wr_word[gi*8 +: 8]   = acc_be[gi] ? acc_data[gi*8 +: 8] : 8'h00;
        end
    endgenerate

    assign wr_en = do_access && !acc_rnw && !mis && !Rst;

    // Sequencer: IDLE/RESP accept, BUSY counts the wait cycles down.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
        end else begin
            case (state_reg)
                IDLE, RESP: begin
                    if (accept) begin
                        if (LATENCY == 0) begin
                            state_reg <= RESP;
                        end else begin
                            state_reg <= BUSY;
                            cnt_reg   <= LAT;
                        end
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                BUSY: begin
                    if (cnt_reg > 4'd1) begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end else begin
                        cnt_reg   <= 4'd0;
                        state_reg <= RESP;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    cnt_reg   <= 4'd0;
                end
            endcase
        end
    end

    // Misaligned flag lives only for the RESP cycle following an access.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            misaligned_reg <= 1'b0;
        end else begin
            misaligned_reg <= do_access && mis;
        end
    end

    // Per-word written-since-reset bitmap.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            valid_reg <= '0;
        end else if (wr_en) begin
            valid_reg[idx] <= 1'b1;
        end
    end

    // Storage array with per-lane write enables.
    always_ff @(posedge Clk) begin
        if (wr_en) begin
            for (int i = 0; i < LANES; i++) begin
                if (lane_we[i]) begin
                    mem[idx][i*8 +: 8] <= wr_word[i*8 +: 8];
                end
            end
        end
    end

    // Read data register: updates only on an aligned read access.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            DRAMout <= '0;
        end else if (do_access && acc_rnw && !mis) begin
            DRAMout <= valid_reg[idx] ? mem[idx] : '0;
        end
    end

    assign Ready      = (state_reg == RESP);
    assign Misaligned = misaligned_reg;

endmodule

// File: tb/tb_dram_wait.sv
// Testbench for dram_wait: three instances (LATENCY 2, 0, 3) checked
// against a word-array reference model of the memory.
module tb_dram_wait;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        me   [3];
    logic        rnw  [3];
    logic [3:0]  be   [3];
    logic [31:0] addr [3];
    logic [31:0] din  [3];
    logic [31:0] dout [3];
    logic        rdy  [3];
    logic        misf [3];

    int errors = 0;
    int checks = 0;

    logic [31:0] model_mem [3][1024];
    logic [31:0] model_out [3];

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 0 : 3);
    endfunction

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            dram_wait #(
                .DATA_W(32), .ADDR_W(32), .DEPTH_LOG2(10),
                .LATENCY((gi == 0) ? 2 : ((gi == 1) ? 0 : 3))
            ) u_dut (
                .Clk(clk), .Rst(rst),
                .MemoryEnable(me[gi]), .ReadNotWrite(rnw[gi]), .ByteEn(be[gi]),
                .DRAMadd(addr[gi]), .DRAMin(din[gi]), .DRAMout(dout[gi]),
                .Ready(rdy[gi]), .Misaligned(misf[gi])
            );
        end
    endgenerate

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            model_out[k] = 32'h0;
            for (int i = 0; i < 1024; i++) model_mem[k][i] = 32'h0;
        end
    endtask

    // One request on instance k, starting at a negedge. Checks latency,
    // outputs while waiting, the response, and (unless chained) the
    // single-cycle Ready pulse. Returns at a negedge.
    task automatic do_txn(input int k, input bit r, input logic [31:0] a,
                          input logic [3:0] b, input logic [31:0] d,
                          input bit chain, input string tag);
        int n;
        bit seen;
        logic exp_mis;
        logic [31:0] prev;
        logic [31:0] exp_out;
        me[k] = 1'b1; rnw[k] = r; addr[k] = a; be[k] = b; din[k] = d;
        prev    = model_out[k];
        exp_mis = (a[1:0] != 2'b00);
        if (!exp_mis) begin
            if (r) model_out[k] = model_mem[k][a[11:2]];
            else
                for (int i = 0; i < 4; i++)
                    if (b[i]) model_mem[k][a[11:2]][i*8 +: 8] = d[i*8 +: 8];
        end
        exp_out = model_out[k];
        @(posedge clk);
        n = 0;
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (rdy[k] === 1'b1) begin
                seen = 1'b1;
                break;
            end
            checks++;
            if (misf[k] !== 1'b0 || dout[k] !== prev) begin
                errors++;
                $display("FAIL %s wait: mis=%b dout=%h required mis=0 dout=%h", tag, misf[k], dout[k], prev);
            end
            if (lat_of(k) > 0) begin
                me[k]   = 1'($urandom_range(0, 1));
                rnw[k]  = 1'($urandom_range(0, 1));
                addr[k] = $urandom;
                be[k]   = 4'($urandom);
                din[k]  = $urandom;
            end
            @(posedge clk);
            n++;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s timeout: Ready never rose, required after %0d cycles", tag, lat_of(k));
        end else begin
            if (n != lat_of(k)) begin
                errors++;
                $display("FAIL %s latency: got %0d required %0d", tag, n, lat_of(k));
            end
            checks++;
            if (misf[k] !== exp_mis) begin
                errors++;
                $display("FAIL %s misaligned: got %b required %b", tag, misf[k], exp_mis);
            end
            checks++;
            if (dout[k] !== exp_out) begin
                errors++;
                $display("FAIL %s dout: got %h required %h", tag, dout[k], exp_out);
            end
        end
        $display("txn %s inst%0d %s addr=%h be=%h din=%h dout=%h mis=%b lat=%0d",
                 tag, k, r ? "RD" : "WR", a, b, d, dout[k], misf[k], n);
        if (!chain) begin
            me[k] = 1'b0;
            @(negedge clk);
            checks++;
            if (rdy[k] !== 1'b0 || misf[k] !== 1'b0 || dout[k] !== exp_out) begin
                errors++;
                $display("FAIL %s pulse: rdy=%b mis=%b dout=%h required 0 0 %h", tag, rdy[k], misf[k], dout[k], exp_out);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (dout[k] !== 32'h0 || rdy[k] !== 1'b0 || misf[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_state inst%0d: dout=%h rdy=%b mis=%b required 0 0 0", k, dout[k], rdy[k], misf[k]);
            end
        end
        do_txn(0, 1'b1, 32'h0, 4'hF, 32'h0, 1'b0, "rd0_after_reset");
        // Load non-zero data, then reset mid-cycle while Ready is high.
        do_txn(0, 1'b0, 32'h8, 4'hF, 32'hCAFEF00D, 1'b1, "wr8");
        do_txn(0, 1'b1, 32'h8, 4'hF, 32'h0, 1'b1, "rd8");
        me[0] = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (dout[0] !== 32'h0 || rdy[0] !== 1'b0 || misf[0] !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: dout=%h rdy=%b mis=%b required 0 0 0", dout[0], rdy[0], misf[0]);
        end
        #1 rst = 1'b0;
        model_reset();
        @(negedge clk);
        do_txn(0, 1'b1, 32'h8, 4'hF, 32'h0, 1'b0, "rd8_cleared");
    endtask

    task automatic test_latency();
        do_txn(0, 1'b0, 32'h10, 4'hF, 32'hDEADBEEF, 1'b1, "lat_wr10");
        do_txn(0, 1'b1, 32'h10, 4'hF, 32'h0, 1'b0, "lat_rd10");
        checks++;
        if (dout[0] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL lat_value: got %h required deadbeef", dout[0]);
        end
    endtask

    task automatic test_byte_en();
        do_txn(0, 1'b0, 32'h20, 4'hF, 32'h11223344, 1'b0, "be_init");
        do_txn(0, 1'b0, 32'h20, 4'h5, 32'hAABBCCDD, 1'b0, "be_wr5");
        do_txn(0, 1'b1, 32'h20, 4'h0, 32'h0, 1'b0, "be_rd");
        checks++;
        if (dout[0] !== 32'h11BB33DD) begin
            errors++;
            $display("FAIL be_value: got %h required 11bb33dd", dout[0]);
        end
        do_txn(0, 1'b0, 32'h20, 4'h0, 32'hFFFFFFFF, 1'b0, "be_zero");
    endtask

    task automatic test_misaligned();
        do_txn(0, 1'b1, 32'h22, 4'hF, 32'h0, 1'b0, "mis_rd22");
        do_txn(0, 1'b0, 32'h23, 4'hF, 32'hFFFFFFFF, 1'b0, "mis_wr23");
        do_txn(0, 1'b1, 32'h20, 4'hF, 32'h0, 1'b0, "mis_rd20");
        checks++;
        if (dout[0] !== 32'h11BB33DD) begin
            errors++;
            $display("FAIL mis_unchanged: got %h required 11bb33dd", dout[0]);
        end
    endtask

    task automatic test_back_to_back();
        for (int j = 0; j < 4; j++)
            do_txn(1, 1'b0, 32'(j * 4), 4'hF, $urandom, 1'b1, "b2b_wr");
        for (int j = 0; j < 4; j++)
            do_txn(1, 1'b1, 32'(j * 4), 4'hF, $urandom, (j != 3), "b2b_rd");
        do_txn(1, 1'b0, 32'h1010, 4'hF, 32'h600DF00D, 1'b1, "alias_wr");
        do_txn(1, 1'b1, 32'h10, 4'hF, 32'h0, 1'b0, "alias_rd");
        checks++;
        if (dout[1] !== 32'h600DF00D) begin
            errors++;
            $display("FAIL alias_value: got %h required 600df00d", dout[1]);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 2; k++) begin
            for (int t = 0; t < 40; t++) begin
                logic [31:0] a;
                a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2);
                if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
                do_txn(k, 1'($urandom_range(0, 1)), a, 4'($urandom), $urandom,
                       (t != 39) && ($urandom_range(0, 1) == 1), "rand");
            end
        end
    endtask

    task automatic test_reset_mid_write();
        do_txn(2, 1'b0, 32'h40, 4'hF, 32'h12345678, 1'b0, "rmw_init");
        do_txn(2, 1'b1, 32'h40, 4'hF, 32'h0, 1'b0, "rmw_rd");
        me[2] = 1'b1; rnw[2] = 1'b0; addr[2] = 32'h40; be[2] = 4'hF; din[2] = 32'h55;
        @(posedge clk);
        @(negedge clk);
        me[2] = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (dout[2] !== 32'h0 || rdy[2] !== 1'b0) begin
            errors++;
            $display("FAIL rmw_async: dout=%h rdy=%b required 0 0", dout[2], rdy[2]);
        end
        #1 rst = 1'b0;
        model_reset();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (rdy[2] !== 1'b0) begin
                errors++;
                $display("FAIL rmw_no_ready: rdy=%b required 0 at cycle %0d", rdy[2], c);
            end
        end
        do_txn(2, 1'b1, 32'h40, 4'hF, 32'h0, 1'b0, "rmw_rd_after");
        checks++;
        if (dout[2] !== 32'h0) begin
            errors++;
            $display("FAIL rmw_value: got %h required 0", dout[2]);
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            me[k] = 1'b0; rnw[k] = 1'b0; be[k] = 4'h0; addr[k] = 32'h0; din[k] = 32'h0;
        end
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        test_reset();
        test_latency();
        test_byte_en();
        test_misaligned();
        test_back_to_back();
        test_random();
        test_reset_mid_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
